// File: rtl/smi_byte_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : smi_byte_serializer_pkg
// Brief    : Shared constants, types and helpers for the SMI byte serializer.
// Revision : 1.0
// ============================================================================
package smi_byte_serializer_pkg;

    localparam int         c_DATA_WIDTH_DEF = 32;
    localparam logic [7:0] c_FILL_BYTE_DEF  = 8'h00;
    localparam int         c_BYTES_PER_WORD = c_DATA_WIDTH_DEF / 8;
    localparam int         c_BYTE_IDX_W     = (c_BYTES_PER_WORD > 1) ? $clog2(c_BYTES_PER_WORD) : 1;

    typedef logic [7:0] smi_byte_t;

    // A one-byte word still needs a 1-bit index so the datapath stays uniform.
    function automatic int byte_idx_width(input int data_width);
        int bpw;
        bpw = data_width / 8;
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/smi_byte_serializer_strobe_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : strobe_sync_edge
// Brief    : N-flop synchroniser for an idle-high async strobe + rise detect.
// Revision : 1.0
// ============================================================================
module strobe_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    output logic rise_o
);

    logic [STAGES-1:0] r_sync;

    // Newest sample enters at bit 0; reset to idle so no false edge appears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], strobe_i};
        end
    end

    assign rise_o = r_sync[STAGES-2] & ~r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/smi_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : smi_byte_serializer
// Brief    : Streams FIFO words to the SMI host one byte per nRE strobe.
// Revision : 1.0
// ============================================================================
module smi_byte_serializer
    import smi_byte_serializer_pkg::*;
#(
    parameter int         DATA_WIDTH  = c_DATA_WIDTH_DEF,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = c_FILL_BYTE_DEF,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  clr_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic                  smi_nre_i,
    output logic [7:0]            smi_data_o,
    output logic                  word_valid_o,
    output logic                  underrun_o,
    output logic [CNT_WIDTH-1:0]  underrun_cnt_o
);

    localparam int                 c_BPW      = DATA_WIDTH / 8;
    localparam int                 c_IDX_W    = byte_idx_width(DATA_WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BPW - 1);

    logic                  w_consume;
    logic                  w_fetch;
    logic                  w_underrun_evt;

    logic [DATA_WIDTH-1:0] r_cur, r_nxt;
    logic                  r_cur_valid, r_nxt_valid;
    logic                  r_fetch_pending;
    logic [c_IDX_W-1:0]    r_byte_idx;
    smi_byte_t             r_smi_data;
    logic                  r_underrun;
    logic [CNT_WIDTH-1:0]  r_underrun_cnt;

    logic [DATA_WIDTH-1:0] w_cur_n, w_nxt_n;
    logic                  w_cur_valid_n, w_nxt_valid_n;
    logic [c_IDX_W-1:0]    w_idx_n;
    logic [DATA_WIDTH-1:0] w_cur_shifted;
    smi_byte_t             w_cur_byte;

    strobe_sync_edge #(
        .STAGES   (SYNC_STAGES)
    ) u_nre_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .strobe_i (smi_nre_i),
        .rise_o   (w_consume)
    );

    // Never two reads in a row, so the FIFO empty flag is always current.
    assign w_fetch = !rst_i && enable_i && !fifo_empty_i && !r_fetch_pending
                     && !(r_cur_valid && r_nxt_valid);

    // Consume/promote resolves first; the landing FIFO word then fills the
    // first free slot, so a promote and a capture in one cycle lose nothing.
    always_comb begin
        w_cur_n        = r_cur;
        w_nxt_n        = r_nxt;
        w_cur_valid_n  = r_cur_valid;
        w_nxt_valid_n  = r_nxt_valid;
        w_idx_n        = r_byte_idx;
        w_underrun_evt = 1'b0;

        if (w_consume) begin
            if (r_cur_valid) begin
                if (r_byte_idx == c_LAST_IDX) begin
                    w_idx_n       = '0;
                    w_cur_n       = r_nxt;
                    w_cur_valid_n = r_nxt_valid;
                    w_nxt_valid_n = 1'b0;
                end else begin
                    w_idx_n = r_byte_idx + c_IDX_W'(1);
                end
            end else begin
                w_underrun_evt = 1'b1;
            end
        end

        if (r_fetch_pending) begin
            if (!w_cur_valid_n) begin
                w_cur_n       = fifo_data_i;
                w_cur_valid_n = 1'b1;
            end else begin
                w_nxt_n       = fifo_data_i;
                w_nxt_valid_n = 1'b1;
            end
        end
    end

    // MSB-first: shift the selected byte up to the top of the word.
    assign w_cur_shifted = r_cur << {r_byte_idx, 3'b000};
    assign w_cur_byte    = w_cur_shifted[DATA_WIDTH-1 -: 8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cur_valid     <= 1'b0;
            r_nxt_valid     <= 1'b0;
            r_fetch_pending <= 1'b0;
            r_byte_idx      <= '0;
            r_smi_data      <= FILL_BYTE;
        end else begin
            r_cur_valid     <= w_cur_valid_n;
            r_nxt_valid     <= w_nxt_valid_n;
            r_fetch_pending <= w_fetch;
            r_byte_idx      <= w_idx_n;
            r_smi_data      <= r_cur_valid ? w_cur_byte : FILL_BYTE;
        end
    end

    always_ff @(posedge clk_i) begin
        r_cur <= w_cur_n;
        r_nxt <= w_nxt_n;
    end

    // A clear that coincides with an underrun still records that underrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else if (clr_i) begin
            r_underrun     <= w_underrun_evt;
            r_underrun_cnt <= w_underrun_evt ? CNT_WIDTH'(1) : '0;
        end else if (w_underrun_evt) begin
            r_underrun <= 1'b1;
            if (r_underrun_cnt != '1) begin
                r_underrun_cnt <= r_underrun_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign fifo_rd_en_o   = w_fetch;
    assign smi_data_o     = r_smi_data;
    assign word_valid_o   = r_cur_valid;
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_underrun_cnt;

endmodule
`default_nettype wire
